// File: rtl/arrow_controller.sv
// Arrow shot controller: launches an arrow from the character on a fire edge and grows it
// upward one step per frame. A bubble hit or reaching the top row ends the flight.
module arrow_controller #(
  parameter int FLOOR_Y         = 440,
  parameter int ARROW_SPEED     = 4,
  parameter int CHAR_WIDTH      = 32,
  parameter int ARROW_WIDTH     = 4,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic [10:0] charX,
  input  logic        arrowHitBubble,
  output logic        arrowActive,
  output logic [10:0] arrowTopLeftX,
  output logic [10:0] arrowTopLeftY,
  output logic [10:0] arrowHeight,
  output logic        bubblePop
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FLYING   = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  localparam logic [10:0] X_OFFSET = 11'((CHAR_WIDTH - ARROW_WIDTH) / 2);
  localparam logic [10:0] FLOOR    = 11'(FLOOR_Y);
  localparam logic [10:0] SPEED    = 11'(ARROW_SPEED);
  localparam logic [10:0] LAUNCH_Y = 11'(FLOOR_Y - ARROW_SPEED);

  localparam int unsigned CNT_W = $clog2(COOLDOWN_FRAMES + 2);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] COOL_ONE  = CNT_W'(1);

  logic [1:0]       state, stateD;
  logic             fireQ;
  logic             edgeArmed;
  logic             firePending, pendingD;
  logic             hitLatch, hitD;
  logic [CNT_W-1:0] coolCnt, coolD;
  logic [10:0]      xQ, xD;
  logic [10:0]      yQ, yD;
  logic [10:0]      heightQ, heightD;
  logic             activeQ, activeD;
  logic             popQ, popD;
  logic             fireEdge;
  logic             hitNow;

  // edgeArmed masks the first sample after reset so a key held through release is not an edge
  assign fireEdge = fire & ~fireQ & edgeArmed;
  assign hitNow   = hitLatch | arrowHitBubble;

  always_comb begin
    stateD   = state;
    pendingD = firePending;
    hitD     = hitLatch;
    coolD    = coolCnt;
    xD       = xQ;
    yD       = yQ;
    heightD  = heightQ;
    activeD  = activeQ;
    popD     = 1'b0;

    if (startOfFrame) begin
      pendingD = 1'b0;
      hitD     = 1'b0;
      case (state)
        IDLE: begin
          if (firePending || fireEdge) begin
            stateD  = FLYING;
            xD      = charX + X_OFFSET;
            yD      = LAUNCH_Y;
            heightD = FLOOR - LAUNCH_Y;
            activeD = 1'b1;
          end
        end
        FLYING: begin
          if (hitNow || (yQ == 11'd0)) begin
            popD    = hitNow;
            stateD  = COOLDOWN;
            activeD = 1'b0;
            heightD = 11'd0;
            coolD   = COOL_LOAD;
          end else begin
            yD      = (yQ < SPEED) ? 11'd0 : yQ - SPEED;
            heightD = FLOOR - yD;
          end
        end
        COOLDOWN: begin
          // a zero load also returns on the first frame
          if (coolCnt <= COOL_ONE) begin
            stateD = IDLE;
            coolD  = '0;
          end else begin
            coolD = coolCnt - COOL_ONE;
          end
        end
        default: begin
          stateD  = IDLE;
          activeD = 1'b0;
          heightD = 11'd0;
        end
      endcase
    end else begin
      if (fireEdge) pendingD = 1'b1;
      if ((state == FLYING) && arrowHitBubble) hitD = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fireQ       <= 1'b0;
      edgeArmed   <= 1'b0;
      firePending <= 1'b0;
      hitLatch    <= 1'b0;
      coolCnt     <= '0;
      xQ          <= 11'd0;
      yQ          <= 11'd0;
      heightQ     <= 11'd0;
      activeQ     <= 1'b0;
      popQ        <= 1'b0;
    end else begin
      state       <= stateD;
      fireQ       <= fire;
      edgeArmed   <= 1'b1;
      firePending <= pendingD;
      hitLatch    <= hitD;
      coolCnt     <= coolD;
      xQ          <= xD;
      yQ          <= yD;
      heightQ     <= heightD;
      activeQ     <= activeD;
      popQ        <= popD;
    end
  end

  assign arrowActive   = activeQ;
  assign arrowTopLeftX = xQ;
  assign arrowTopLeftY = yQ;
  assign arrowHeight   = heightQ;
  assign bubblePop     = popQ;

endmodule

// File: tb/tb_arrow_controller.sv
// Bench for arrow_controller: directed scenarios followed by random traffic, all checked
// against a frame-level reference model.
module tb_arrow_controller;

  localparam int FLOOR_Y         = 440;
  localparam int ARROW_SPEED     = 4;
  localparam int CHAR_WIDTH      = 32;
  localparam int ARROW_WIDTH     = 4;
  localparam int COOLDOWN_FRAMES = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        fire;
  logic [10:0] charX;
  logic        arrowHitBubble;
  logic        arrowActive;
  logic [10:0] arrowTopLeftX;
  logic [10:0] arrowTopLeftY;
  logic [10:0] arrowHeight;
  logic        bubblePop;

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0 idle, 1 flying, 2 cooldown; Y derived from frames flown
  int mMode, mFrames, mCoolSeen, mX, mY;
  bit mPending, mHitSticky, mPrev, mKnown, mPop;

  arrow_controller #(
    .FLOOR_Y        (FLOOR_Y),
    .ARROW_SPEED    (ARROW_SPEED),
    .CHAR_WIDTH     (CHAR_WIDTH),
    .ARROW_WIDTH    (ARROW_WIDTH),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .fire          (fire),
    .charX         (charX),
    .arrowHitBubble(arrowHitBubble),
    .arrowActive   (arrowActive),
    .arrowTopLeftX (arrowTopLeftX),
    .arrowTopLeftY (arrowTopLeftY),
    .arrowHeight   (arrowHeight),
    .bubblePop     (bubblePop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".active"}, 32'(arrowActive), 32'(mMode == 1));
    check({tag, ".x"}, 32'(arrowTopLeftX), 32'(mX));
    check({tag, ".y"}, 32'(arrowTopLeftY), 32'(mY));
    check({tag, ".height"}, 32'(arrowHeight), (mMode == 1) ? 32'(FLOOR_Y - mY) : 32'd0);
    check({tag, ".pop"}, 32'(bubblePop), 32'(mPop));
  endtask

  task automatic modelReset();
    mMode = 0; mFrames = 0; mCoolSeen = 0; mX = 0; mY = 0;
    mPending = 0; mHitSticky = 0; mPrev = 0; mKnown = 0; mPop = 0;
  endtask

  task automatic modelEdge(input bit sof, input bit f, input bit h);
    bit fireRise;
    bit hitSeen;
    fireRise = f && mKnown && !mPrev;
    hitSeen  = mHitSticky || h;
    mPop = 0;
    if (sof) begin
      if (mMode == 0) begin
        if (mPending || fireRise) begin
          mMode = 1;
          mFrames = 1;
          mX = (int'(charX) + (CHAR_WIDTH - ARROW_WIDTH) / 2) % 2048;
          mY = FLOOR_Y - ARROW_SPEED;
        end
      end else if (mMode == 1) begin
        if (hitSeen || mY == 0) begin
          mPop = hitSeen;
          mMode = 2;
          mCoolSeen = 0;
        end else begin
          mFrames++;
          mY = FLOOR_Y - ARROW_SPEED * mFrames;
          if (mY < 0) mY = 0;
        end
      end else begin
        mCoolSeen++;
        if (mCoolSeen >= ((COOLDOWN_FRAMES < 1) ? 1 : COOLDOWN_FRAMES)) mMode = 0;
      end
      mPending = 0;
      mHitSticky = 0;
    end else begin
      if (fireRise) mPending = 1;
      if (mMode == 1 && h) mHitSticky = 1;
    end
    mPrev = f;
    mKnown = 1;
  endtask

  task automatic tick(input string tag, input bit sof, input bit f, input bit h);
    startOfFrame = sof;
    fire = f;
    arrowHitBubble = h;
    @(posedge clk);
    modelEdge(sof, f, h);
    #1;
    checkAll(tag);
  endtask

  task automatic plainFrames(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick(tag, 0, 0, 0); tick(tag, 0, 0, 0); tick(tag, 0, 0, 0); tick(tag, 1, 0, 0);
    end
  endtask

  task automatic fireFrame(input string tag);
    tick(tag, 0, 1, 0); tick(tag, 0, 0, 0); tick(tag, 0, 0, 0); tick(tag, 1, 0, 0);
  endtask

  // Assert reset between edges, check outputs clear without a clock, release later
  task automatic applyReset(input string tag, input bit fireLevel);
    reset = 1'b1;
    fire = fireLevel;
    startOfFrame = 1'b0;
    arrowHitBubble = 1'b0;
    #1;
    check({tag, ".active"}, 32'(arrowActive), 32'd0);
    check({tag, ".x"}, 32'(arrowTopLeftX), 32'd0);
    check({tag, ".y"}, 32'(arrowTopLeftY), 32'd0);
    check({tag, ".height"}, 32'(arrowHeight), 32'd0);
    check({tag, ".pop"}, 32'(bubblePop), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    bit rf;
    reset = 1'b1;
    startOfFrame = 1'b0;
    fire = 1'b0;
    arrowHitBubble = 1'b0;
    charX = 11'd0;
    modelReset();
    #2;
    applyReset("reset", 0);

    // Launch from charX=100
    charX = 11'd100;
    tick("launch", 0, 0, 0); tick("launch", 0, 1, 0); tick("launch", 1, 1, 0);
    check("launch.activeLit", 32'(arrowActive), 32'd1);
    check("launch.xLit", 32'(arrowTopLeftX), 32'd114);
    check("launch.yLit", 32'(arrowTopLeftY), 32'd436);
    check("launch.heightLit", 32'(arrowHeight), 32'd4);

    // Fly to the top with fire presses mid-flight that must be dropped
    for (int i = 0; i < 109; i++) begin
      tick("fly", 0, (i % 10) == 3, 0); tick("fly", 0, 0, 0); tick("fly", 0, 0, 0);
      tick("fly", 1, 0, 0);
    end
    check("top.yLit", 32'(arrowTopLeftY), 32'd0);
    check("top.heightLit", 32'(arrowHeight), 32'd440);
    check("top.activeLit", 32'(arrowActive), 32'd1);
    plainFrames("topEnd", 1);
    check("topEnd.activeLit", 32'(arrowActive), 32'd0);
    check("topEnd.popLit", 32'(bubblePop), 32'd0);

    // Cooldown lockout, then relaunch after the 8th cooldown frame
    for (int i = 0; i < 7; i++) begin
      fireFrame("lockout");
      check("lockout.activeLit", 32'(arrowActive), 32'd0);
    end
    plainFrames("cool8", 1);
    check("cool8.activeLit", 32'(arrowActive), 32'd0);
    fireFrame("relaunch");
    check("relaunch.activeLit", 32'(arrowActive), 32'd1);

    // Pop at Y=300 from a mid-frame hit
    plainFrames("toPop", 34);
    check("prePop.yLit", 32'(arrowTopLeftY), 32'd300);
    tick("pop", 0, 0, 1); tick("pop", 0, 0, 0); tick("pop", 0, 0, 0); tick("pop", 1, 0, 0);
    check("pop.popLit", 32'(bubblePop), 32'd1);
    check("pop.activeLit", 32'(arrowActive), 32'd0);
    check("pop.yLit", 32'(arrowTopLeftY), 32'd300);
    tick("popAfter", 0, 0, 0);
    check("popAfter.popLit", 32'(bubblePop), 32'd0);
    plainFrames("cool", 8);

    // Hit coinciding with startOfFrame
    charX = 11'd2040;
    fireFrame("launch2");
    plainFrames("fly2", 5);
    tick("sameHit", 0, 0, 0); tick("sameHit", 0, 0, 0); tick("sameHit", 0, 0, 0);
    tick("sameHit", 1, 0, 1);
    check("sameHit.popLit", 32'(bubblePop), 32'd1);
    plainFrames("cool", 8);

    // Reset mid-flight with fire held through release
    charX = 11'd300;
    fireFrame("launch3");
    plainFrames("fly3", 59);
    check("preReset.yLit", 32'(arrowTopLeftY), 32'd200);
    tick("holdFire", 0, 1, 0);
    applyReset("midReset", 1);
    for (int i = 0; i < 3; i++) begin
      tick("held", 0, 1, 0); tick("held", 0, 1, 0); tick("held", 0, 1, 0); tick("held", 1, 1, 0);
      check("held.activeLit", 32'(arrowActive), 32'd0);
    end
    tick("refire", 0, 0, 0); tick("refire", 0, 1, 0); tick("refire", 0, 1, 0);
    tick("refire", 1, 1, 0);
    check("refire.activeLit", 32'(arrowActive), 32'd1);

    // Random traffic
    rf = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rf = ~rf;
      if ($urandom_range(0, 49) == 0) charX = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 999) == 0) applyReset("randReset", rf);
      tick("rand", $urandom_range(0, 3) == 0, rf, $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
